soc_multicore_trace_collector: RTL and testbench

// - Synthesizable N-core successor of the per-core simulation trace monitors:

---
 rtl/soc_multicore_trace_collector_if.sv | 34 +++
 rtl/soc_multicore_trace_collector.sv | 171 +++++++++++++++++
 tb/tb_soc_multicore_trace_collector.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/soc_multicore_trace_collector_if.sv
// Trace-collector bus: per-core retire stream in, counters/putc/status out.
// The trace side is the master; the collector is the slave.
interface soc_multicore_trace_collector_if #(
  parameter int NUM_CORES = 8,
  parameter int CNT_WIDTH = 32
);
  localparam int SW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  logic [NUM_CORES-1:0]    trc_valid;
  logic [NUM_CORES*32-1:0] trc_insn;
  logic [NUM_CORES*32-1:0] trc_r3;
  logic [SW-1:0]           cnt_sel;
  logic [CNT_WIDTH-1:0]    cnt_value;
  logic [31:0]             exit_code;
  logic                    putc_valid;
  logic [SW-1:0]           putc_core;
  logic [7:0]              putc_char;
  logic [NUM_CORES-1:0]    putc_ovf;
  logic [NUM_CORES-1:0]    term_vec;
  logic                    done;
  logic                    timeout;

  modport master (
    output trc_valid, trc_insn, trc_r3, cnt_sel,
    input  cnt_value, exit_code, putc_valid, putc_core,
    input  putc_char, putc_ovf, term_vec, done, timeout
  );

  modport slave (
    input  trc_valid, trc_insn, trc_r3, cnt_sel,
    output cnt_value, exit_code, putc_valid, putc_core,
    output putc_char, putc_ovf, term_vec, done, timeout
  );
endinterface

// File: rtl/soc_multicore_trace_collector.sv
// N-core retire monitor: l.nop terminate/putc decode, counters, putc arbiter.
// Optional idle watchdog enabled by defining SOC_TRACE_WDOG_EN.
module soc_multicore_trace_collector #(
  parameter int          NUM_CORES   = 8,
  parameter int          CNT_WIDTH   = 32,
  parameter logic [15:0] NOP_TERM    = 16'h0001,
  parameter logic [15:0] NOP_PUTC    = 16'h0004,
  parameter int          WDOG_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  soc_multicore_trace_collector_if.slave bus
);
  localparam int SW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam logic [31:0] TERM_INSN = {16'h1500, NOP_TERM};
  localparam logic [31:0] PUTC_INSN = {16'h1500, NOP_PUTC};
  localparam logic [SW-1:0] LAST = SW'(NUM_CORES - 1);

  if (NUM_CORES < 1 || NUM_CORES > 64 || WDOG_CYCLES < 1) begin : g_prm_chk
    $error("soc_multicore_trace_collector: parameter out of range");
  end

  typedef enum logic [1:0] { RUN, DRAIN, DONE, TMO } state_e;

  state_e state_q, state_d;

  logic [CNT_WIDTH-1:0] cnt_q  [NUM_CORES];
  logic [CNT_WIDTH-1:0] cnt_d  [NUM_CORES];
  logic [31:0]          exit_q [NUM_CORES];
  logic [31:0]          exit_d [NUM_CORES];
  logic [7:0]           ch_q   [NUM_CORES];
  logic [7:0]           ch_d   [NUM_CORES];

  logic [NUM_CORES-1:0] term_q, term_d;
  logic [NUM_CORES-1:0] full_q, full_d;
  logic [NUM_CORES-1:0] ovf_q, ovf_d;
  logic [SW-1:0]        ptr_q, ptr_d;
  logic [SW-1:0]        gnt;
  logic                 gnt_any;
  logic                 wdog_hit;

  logic                 pv_q;
  logic [SW-1:0]        pcore_q;
  logic [7:0]           pch_q;

  // Lowest offset from the pointer wins, so scan offsets downwards.
  always_comb begin
    gnt_any = 1'b0;
    gnt     = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (full_q[(int'(ptr_q) + i) % NUM_CORES]) begin
        gnt_any = 1'b1;
        gnt     = SW'((int'(ptr_q) + i) % NUM_CORES);
      end
    end
    if (state_q == TMO) gnt_any = 1'b0;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any) ptr_d = (gnt == LAST) ? '0 : gnt + 1'b1;
  end

  // Slot is freed by a grant before the refill check, so grant+refill
  // in one cycle stores the new character without overflow.
  always_comb begin
    cnt_d  = cnt_q;
    exit_d = exit_q;
    ch_d   = ch_q;
    term_d = term_q;
    full_d = full_q;
    ovf_d  = ovf_q;
    if (gnt_any) full_d[gnt] = 1'b0;
    for (int c = 0; c < NUM_CORES; c++) begin
      if (bus.trc_valid[c] && !term_q[c]) begin
        if (cnt_q[c] != '1) cnt_d[c] = cnt_q[c] + 1'b1;
        if (bus.trc_insn[32*c +: 32] == TERM_INSN) begin
          term_d[c] = 1'b1;
          exit_d[c] = bus.trc_r3[32*c +: 32];
        end
        if (bus.trc_insn[32*c +: 32] == PUTC_INSN) begin
          if (full_d[c]) begin
            ovf_d[c] = 1'b1;
          end else begin
            full_d[c] = 1'b1;
            ch_d[c]   = bus.trc_r3[32*c +: 8];
          end
        end
      end
    end
  end

`ifdef SOC_TRACE_WDOG_EN
  localparam int IW = $clog2(WDOG_CYCLES + 1);
  logic [IW-1:0] idle_q, idle_d;

  always_comb begin
    idle_d = idle_q;
    if (|bus.trc_valid) idle_d = '0;
    else if (idle_q != IW'(WDOG_CYCLES)) idle_d = idle_q + 1'b1;
  end

  assign wdog_hit    = (idle_d == IW'(WDOG_CYCLES));
  assign bus.timeout = (state_q == TMO);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) idle_q <= '0;
    else     idle_q <= idle_d;
  end
`else
  assign wdog_hit    = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      state_q == RUN: begin
        if (&term_q) state_d = (|full_q) ? DRAIN : DONE;
      end
      state_q == DRAIN: begin
        if (!(|full_q)) state_d = DONE;
      end
      default: ;
    endcase
    if (wdog_hit && (state_q == RUN || state_q == DRAIN)) state_d = TMO;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      term_q  <= '0;
      full_q  <= '0;
      ovf_q   <= '0;
      ptr_q   <= '0;
      pv_q    <= 1'b0;
      pcore_q <= '0;
      pch_q   <= '0;
      for (int c = 0; c < NUM_CORES; c++) begin
        cnt_q[c]  <= '0;
        exit_q[c] <= '0;
        ch_q[c]   <= '0;
      end
    end else begin
      state_q <= state_d;
      term_q  <= term_d;
      full_q  <= full_d;
      ovf_q   <= ovf_d;
      ptr_q   <= ptr_d;
      pv_q    <= gnt_any;
      if (gnt_any) begin
        pcore_q <= gnt;
        pch_q   <= ch_q[gnt];
      end
      for (int c = 0; c < NUM_CORES; c++) begin
        cnt_q[c]  <= cnt_d[c];
        exit_q[c] <= exit_d[c];
        ch_q[c]   <= ch_d[c];
      end
    end
  end

  assign bus.cnt_value  = cnt_q[bus.cnt_sel];
  assign bus.exit_code  = exit_q[bus.cnt_sel];
  assign bus.putc_valid = pv_q;
  assign bus.putc_core  = pcore_q;
  assign bus.putc_char  = pch_q;
  assign bus.putc_ovf   = ovf_q;
  assign bus.term_vec   = term_q;
  assign bus.done       = (state_q == DONE);
endmodule

// File: tb/tb_soc_multicore_trace_collector.sv
// Directed bench for soc_multicore_trace_collector (4 cores, 4-bit counters)
// with a cycle-level behavioural model and literal spot checks.
module tb_soc_multicore_trace_collector;
  localparam int N  = 4;
  localparam int CW = 4;
  localparam int WD = 16;
  localparam logic [31:0] PLAIN = 32'h1500_0002;
  localparam logic [31:0] TERM  = 32'h1500_0001;
  localparam logic [31:0] PUTC  = 32'h1500_0004;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] v = '0;
  logic [31:0] ins [N];
  logic [31:0] r3v [N];
  int errors = 0;
  int checks = 0;
  int q[$];

  soc_multicore_trace_collector_if #(.NUM_CORES(N), .CNT_WIDTH(CW)) bus ();

  soc_multicore_trace_collector #(
    .NUM_CORES(N), .CNT_WIDTH(CW), .WDOG_CYCLES(WD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always_comb begin
    bus.trc_valid = '0;
    bus.trc_insn  = '0;
    bus.trc_r3    = '0;
    bus.trc_valid = v;
    for (int c = 0; c < N; c++) begin
      bus.trc_insn[32*c +: 32] = ins[c];
      bus.trc_r3[32*c +: 32]   = r3v[c];
    end
  end

  task automatic chk(string n, logic [63:0] a, logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  // Behavioural model: cores, holding slots, round-robin emission, state.
  int m_cnt [N];
  bit m_term [N];
  logic [31:0] m_ex [N];
  bit m_full [N];
  logic [7:0] m_ch [N];
  logic [N-1:0] m_ovf;
  int m_ptr, m_pc, m_st, m_idle;
  bit m_pv;
  logic [7:0] m_pch;

  always @(posedge clk or posedge rst) begin
    int g, nst;
    bit all_t, any_f;
    if (rst) begin
      for (int c = 0; c < N; c++) begin
        m_cnt[c] = 0; m_term[c] = 0; m_ex[c] = 0;
        m_full[c] = 0; m_ch[c] = 0;
      end
      m_ovf = 0; m_ptr = 0; m_pv = 0; m_pc = 0; m_pch = 0;
      m_st = 0; m_idle = 0;
    end else begin
      all_t = 1; any_f = 0; g = -1;
      for (int c = 0; c < N; c++) begin
        all_t &= m_term[c];
        any_f |= m_full[c];
      end
      nst = m_st;
      if (m_st == 0 && all_t) nst = any_f ? 1 : 2;
      if (m_st == 1 && !any_f) nst = 2;
      if (m_st != 3)
        for (int i = 0; i < N; i++)
          if (g < 0 && m_full[(m_ptr + i) % N]) g = (m_ptr + i) % N;
      m_pv = (g >= 0);
      if (g >= 0) begin
        m_pc = g; m_pch = m_ch[g]; m_full[g] = 0; m_ptr = (g + 1) % N;
      end
      for (int c = 0; c < N; c++) begin
        if (v[c] && !m_term[c]) begin
          if (m_cnt[c] < 15) m_cnt[c]++;
          if (ins[c] == TERM) begin m_term[c] = 1; m_ex[c] = r3v[c]; end
          if (ins[c] == PUTC) begin
            if (m_full[c]) m_ovf[c] = 1'b1;
            else begin m_full[c] = 1; m_ch[c] = r3v[c][7:0]; end
          end
        end
      end
`ifdef SOC_TRACE_WDOG_EN
      m_idle = (v != 0) ? 0 : ((m_idle < WD) ? m_idle + 1 : WD);
      if ((m_st == 0 || m_st == 1) && m_idle == WD) nst = 3;
`endif
      m_st = nst;
    end
  end

  always @(negedge clk) begin
    logic [3:0] tv;
    if (!rst) begin
      tv = '0;
      for (int c = 0; c < N; c++) tv[c] = m_term[c];
      chk("cnt_value", 64'(bus.cnt_value), 64'(m_cnt[bus.cnt_sel]));
      chk("exit_code", 64'(bus.exit_code), 64'(m_ex[bus.cnt_sel]));
      chk("putc_valid", 64'(bus.putc_valid), 64'(m_pv));
      if (m_pv) begin
        chk("putc_core", 64'(bus.putc_core), 64'(m_pc));
        chk("putc_char", 64'(bus.putc_char), 64'(m_pch));
      end
      chk("putc_ovf", 64'(bus.putc_ovf), 64'(m_ovf));
      chk("term_vec", 64'(bus.term_vec), 64'(tv));
      chk("done", 64'(bus.done), 64'(m_st == 2));
      chk("timeout", 64'(bus.timeout), 64'(m_st == 3));
      if (bus.putc_valid) q.push_back(int'(bus.putc_core) * 256 + int'(bus.putc_char));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic [N-1:0] m, logic [31:0] insn, logic [31:0] base);
    v = m;
    for (int c = 0; c < N; c++) begin
      ins[c] = insn;
      r3v[c] = base + 32'(c);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    v = '0;
    bus.cnt_sel = '0;
    cyc();
    cyc();
    rst = 1'b0;
    q.delete();
  endtask

  initial begin
    bit found;
    for (int c = 0; c < N; c++) begin ins[c] = PLAIN; r3v[c] = 0; end
    bus.cnt_sel = '0;
    do_reset();
    chk("rst_done", 64'(bus.done), 0);
    chk("rst_term", 64'(bus.term_vec), 0);
    chk("rst_cnt", 64'(bus.cnt_value), 0);

    // 10 plain retires then terminate with r3=0x2A on every core
    for (int k = 0; k < 10; k++) begin drive(4'hF, PLAIN, 0); cyc(); end
    for (int c = 0; c < N; c++) begin ins[c] = TERM; r3v[c] = 32'h2A; end
    cyc();
    v = '0;
    chk("term_all", 64'(bus.term_vec), 64'hF);
    chk("done_not_yet", 64'(bus.done), 0);
    cyc();
    chk("done_set", 64'(bus.done), 1);
    for (int c = 0; c < N; c++) begin
      bus.cnt_sel = 2'(c);
      cyc();
      chk("cnt11", 64'(bus.cnt_value), 11);
      chk("exit2a", 64'(bus.exit_code), 64'h2A);
    end

    // simultaneous putc from all cores
    do_reset();
    drive(4'hF, PUTC, 32'h41);
    cyc();
    v = '0;
    for (int k = 0; k < 6; k++) cyc();
    chk("rr_count", 64'(q.size()), 4);
    if (q.size() == 4) begin
      chk("rr0", 64'(q[0]), 64'h041);
      chk("rr1", 64'(q[1]), 64'h142);
      chk("rr2", 64'(q[2]), 64'h243);
      chk("rr3", 64'(q[3]), 64'h344);
    end
    q.delete();
    drive(4'hF, PUTC, 32'h61);
    cyc();
    v = '0;
    for (int k = 0; k < 6; k++) cyc();
    chk("rr_wrap", 64'(q.size() > 0 ? q[0] : -1), 64'h061);

    // cores 1 and 2 stream putc every cycle
    do_reset();
    for (int k = 0; k < 10; k++) begin
      v = 4'b0110;
      ins[1] = PUTC; r3v[1] = 32'h61 + 32'(k);
      ins[2] = PUTC; r3v[2] = 32'h41 + 32'(k);
      cyc();
    end
    v = '0;
    for (int k = 0; k < 4; k++) cyc();
    chk("ovf_bits", 64'(bus.putc_ovf), 64'h6);
    chk("alt_count", 64'(q.size() >= 4), 1);
    if (q.size() >= 4) begin
      chk("alt0", 64'(q[0] / 256), 1);
      chk("alt1", 64'(q[1] / 256), 2);
      chk("alt2", 64'(q[2] / 256), 1);
      chk("alt3", 64'(q[3] / 256), 2);
    end

    // counter saturation
    do_reset();
    for (int k = 0; k < 20; k++) begin drive(4'h1, PLAIN, 0); cyc(); end
    v = '0;
    chk("sat20", 64'(bus.cnt_value), 64'hF);
    cyc();
    chk("sat_hold", 64'(bus.cnt_value), 64'hF);

    // terminate while putc slots still hold characters
    do_reset();
    drive(4'hF, PUTC, 32'h61);
    cyc();
    drive(4'hF, TERM, 32'h10);
    cyc();
    chk("drain_term", 64'(bus.term_vec), 64'hF);
    chk("drain_done0", 64'(bus.done), 0);
    drive(4'h1, PUTC, 32'h78);
    cyc();
    v = '0;
    found = 0;
    for (int k = 0; k < 10 && !found; k++) begin
      if (bus.putc_valid && bus.putc_core == 2'd3) found = 1;
      else cyc();
    end
    chk("drain_emit3", 64'(found), 1);
    chk("drain_done_wait", 64'(bus.done), 0);
    cyc();
    chk("drain_done", 64'(bus.done), 1);
    chk("drain_q", 64'(q.size()), 4);
    chk("frozen_cnt", 64'(bus.cnt_value), 2);

    // async reset mid-run
    do_reset();
    v = 4'b0011;
    ins[0] = PUTC; r3v[0] = 32'h5A;
    ins[1] = TERM; r3v[1] = 32'h7;
    cyc();
    v = '0;
    bus.cnt_sel = 2'd1;
    cyc();
    chk("pre_rst_pv", 64'(bus.putc_valid), 1);
    chk("pre_rst_term", 64'(bus.term_vec), 64'h2);
    rst = 1'b1;
    #1;
    chk("arst_pv", 64'(bus.putc_valid), 0);
    chk("arst_term", 64'(bus.term_vec), 0);
    chk("arst_cnt", 64'(bus.cnt_value), 0);
    chk("arst_exit", 64'(bus.exit_code), 0);
    do_reset();

`ifdef SOC_TRACE_WDOG_EN
    for (int k = 0; k < WD - 1; k++) cyc();
    chk("wdog_early", 64'(bus.timeout), 0);
    cyc();
    chk("wdog_fire", 64'(bus.timeout), 1);
    chk("wdog_done", 64'(bus.done), 0);
    rst = 1'b1;
    #1;
    chk("wdog_arst", 64'(bus.timeout), 0);
    do_reset();
`endif
    cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end
endmodule
